// File: rtl/ctrl_pkg.sv
// Shared decode-stage definitions: opcodes, ALUOp codes, FSM states and the
// ID/EX control bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_MUL = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrlState_t;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluOp;
  } ctrlBundle_t;

  localparam int unsigned BUNDLE_W = $bits(ctrlBundle_t);

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the control bundle plus mul/ecall
// and legality qualifiers for the pipeline FSM.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EXT_JUMP = 1'b0
) (
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  output logic [BUNDLE_W-1:0] bundle,
  output logic                isMul,
  output logic                isEcall,
  output logic                isLegal
);

  ctrlBundle_t dec;

  always_comb begin
    dec     = '0;
    isLegal = 1'b1;
    isEcall = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.regWrite = 1'b1;
        dec.aluOp    = ALUOP_RTYPE;
      end
      OP_IMM: begin
        dec.aluSrc   = 1'b1;
        dec.regWrite = 1'b1;
        dec.aluOp    = ALUOP_ADD;
      end
      OP_LOAD: begin
        dec.aluSrc   = 1'b1;
        dec.memtoReg = 1'b1;
        dec.regWrite = 1'b1;
        dec.memRead  = 1'b1;
      end
      OP_STORE: begin
        dec.aluSrc   = 1'b1;
        dec.memWrite = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.aluOp  = ALUOP_BRANCH;
      end
      OP_NOP:    ;
      OP_SYSTEM: isEcall = 1'b1;
      // Jump-class opcodes are only legal when the extension is built in.
      OP_JAL: begin
        if (EXT_JUMP) begin
          dec.regWrite = 1'b1;
          dec.jump     = 1'b1;
          dec.aluOp    = ALUOP_JUMP;
        end else begin
          isLegal = 1'b0;
        end
      end
      OP_JALR: begin
        if (EXT_JUMP) begin
          dec.regWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.jump     = 1'b1;
          dec.aluOp    = ALUOP_JUMP;
        end else begin
          isLegal = 1'b0;
        end
      end
      OP_LUI: begin
        if (EXT_JUMP) begin
          dec.regWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.aluOp    = ALUOP_JUMP;
        end else begin
          isLegal = 1'b0;
        end
      end
      default: isLegal = 1'b0;
    endcase
  end

  assign bundle = dec;
  assign isMul  = (opcode == OP_RTYPE) && (funct7 == F7_MUL);

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID/EX control register with multi-cycle mul stall, ecall halt and a sticky
// illegal-opcode flag.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3,
  parameter bit          EXT_JUMP   = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  input  logic       valid_i,
  input  logic       NoOP_i,
  input  logic       Flush_i,
  output logic       RegWrite_o,
  output logic       MemtoReg_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       ALUSrc_o,
  output logic       Branch_o,
  output logic       Jump_o,
  output logic [1:0] ALUOp_o,
  output logic       Stall_o,
  output logic       Halt_o,
  output logic       IllegalOp_o
);

  localparam int unsigned      CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrlState_t          state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  ctrlBundle_t         bundleQ, bundleNext, decoded;
  logic [BUNDLE_W-1:0] decVec;
  logic                decMul, decEcall, decLegal;
  logic                haltQ, illegalQ, illegalNext;

  ctrl_decode #(.EXT_JUMP(EXT_JUMP)) uDecode (
    .opcode  (opcode_i),
    .funct7  (funct7_i),
    .bundle  (decVec),
    .isMul   (decMul),
    .isEcall (decEcall),
    .isLegal (decLegal)
  );

  assign decoded = decVec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= RUN;
      cnt      <= '0;
      bundleQ  <= '0;
      haltQ    <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      bundleQ  <= bundleNext;
      haltQ    <= (stateNext == HALT);
      illegalQ <= illegalNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    bundleNext  = '0;
    illegalNext = illegalQ;
    case (state)
      RUN: begin
        // Bubbles take priority and must not raise the illegal flag or halt.
        if (Flush_i || NoOP_i || !valid_i) begin
          bundleNext = '0;
        end else if (!decLegal) begin
          illegalNext = 1'b1;
        end else if (decEcall) begin
          stateNext = HALT;
        end else begin
          bundleNext = decoded;
          if (decMul && (MUL_CYCLES > 1)) begin
            cntNext   = CNT_LOAD;
            stateNext = MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        bundleNext = bundleQ;
        cntNext    = cnt - CNT_ONE;
        if (cnt == CNT_ONE) stateNext = RUN;
      end
      HALT:    bundleNext = '0;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    Stall_o     = (state == MUL_WAIT);
    Halt_o      = haltQ;
    IllegalOp_o = illegalQ;
    RegWrite_o  = bundleQ.regWrite;
    MemtoReg_o  = bundleQ.memtoReg;
    MemRead_o   = bundleQ.memRead;
    MemWrite_o  = bundleQ.memWrite;
    ALUSrc_o    = bundleQ.aluSrc;
    Branch_o    = bundleQ.branch;
    Jump_o      = bundleQ.jump;
    ALUOp_o     = bundleQ.aluOp;
  end

endmodule
